// File: rtl/spi_controller_pkg.sv
// spi_controller_pkg
//   Shared types and helpers for the SPI master slice.
//   - state_e      : controller phase encoding
//   - width_for()  : counter width for a 0..n-1 range, never narrower than 1 bit
//   - DEF_*        : default packet width and clock divider
package spi_controller_pkg;

    localparam int DEF_BIT_WIDTH = 20;
    localparam int DEF_CLK_DIV   = 4;

    typedef enum logic [2:0] {
        GAP,
        IDLE,
        LOW,
        HIGH,
        HOLD,
        DONE
    } state_e;

    // A counter covering 0..n-1 needs $clog2(n) bits; a 1-entry range still
    // needs a real (1-bit) register so the logic stays well formed.
    function automatic int width_for(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// spi_controller_if
//   Bundles the upstream request stream, downstream response stream and the
//   four SPI pins of the controller.
//   master modport : the controller (drives rdy/send/cs/sclk/mosi)
//   slave  modport : the environment (drives recv/send_rdy/miso)
interface spi_controller_if
    import spi_controller_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH
);
    logic [BIT_WIDTH-1:0] recv_msg;
    logic                 recv_val;
    logic                 recv_rdy;
    logic [BIT_WIDTH-1:0] send_msg;
    logic                 send_val;
    logic                 send_rdy;
    logic                 cs;
    logic                 sclk;
    logic                 mosi;
    logic                 miso;

    modport master (
        input  recv_msg, recv_val, send_rdy, miso,
        output recv_rdy, send_msg, send_val, cs, sclk, mosi
    );

    modport slave (
        output recv_msg, recv_val, send_rdy, miso,
        input  recv_rdy, send_msg, send_val, cs, sclk, mosi
    );
endinterface

// File: rtl/spi_controller_sync_2ff.sv
// spi_sync_2ff
//   Two-flop synchronizer bringing the asynchronous miso pin into clk.
//   clk   : system clock
//   reset : asynchronous active-low reset, both flops clear to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clk cycles of latency)
module spi_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/spi_controller.sv
// spi_controller
//   SPI mode-0 master. Accepts a BIT_WIDTH packet on bus.recv_*, shifts it out
//   MSB-first on mosi while capturing miso, then returns the captured word on
//   bus.send_*. One packet in flight at a time.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset (aborts any transfer)
//   bus   : spi_controller_if.master (streams + cs/sclk/mosi/miso)
module spi_controller
    import spi_controller_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int CLK_DIV   = DEF_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_controller_if.master      bus
);
    localparam int CW = width_for(CLK_DIV);
    localparam int IW = width_for(BIT_WIDTH);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [BIT_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [BIT_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [BIT_WIDTH-1:0] send_msg_q, send_msg_d;
    logic                 cs_q, cs_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 recv_rdy_q, recv_rdy_d;
    logic                 send_val_q, send_val_d;

    logic                 miso_s;
    logic                 cnt_last;
    logic [BIT_WIDTH-1:0] tx_shl;

    spi_sync_2ff u_miso_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.miso),
        .q_o   (miso_s)
    );

    assign cnt_last = (cnt_q == CW'(CLK_DIV - 1));
    assign tx_shl   = tx_shift_q << 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= GAP;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            send_msg_q <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            recv_rdy_q <= 1'b0;
            send_val_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            send_msg_q <= send_msg_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            recv_rdy_q <= recv_rdy_d;
            send_val_q <= send_val_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        send_msg_d = send_msg_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        recv_rdy_d = recv_rdy_q;
        send_val_d = send_val_q;

        unique case (state_q)
            // Minimum cs-high time after reset and between packets.
            GAP: begin
                cs_d = 1'b1;
                if (cnt_last) begin
                    cnt_d      = '0;
                    recv_rdy_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IDLE: begin
                if (bus.recv_val && recv_rdy_q) begin
                    tx_shift_d = bus.recv_msg;
                    recv_rdy_d = 1'b0;
                    cs_d       = 1'b0;
                    mosi_d     = bus.recv_msg[BIT_WIDTH-1];
                    bit_idx_d  = '0;
                    cnt_d      = '0;
                    state_d    = LOW;
                end
            end
            // First LOW after IDLE also provides cs-to-sclk setup.
            LOW: begin
                if (cnt_last) begin
                    sclk_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // miso is sampled as late as possible so minion data launched at
            // the sclk rise has cleared the synchronizer.
            HIGH: begin
                if (cnt_last) begin
                    rx_shift_d = (rx_shift_q << 1) | BIT_WIDTH'(miso_s);
                    sclk_d     = 1'b0;
                    cnt_d      = '0;
                    if (bit_idx_q == IW'(BIT_WIDTH - 1)) begin
                        state_d = HOLD;
                    end else begin
                        tx_shift_d = tx_shl;
                        mosi_d     = tx_shl[BIT_WIDTH-1];
                        bit_idx_d  = bit_idx_q + IW'(1);
                        state_d    = LOW;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // sclk-to-cs hold before releasing the minion.
            HOLD: begin
                if (cnt_last) begin
                    cs_d       = 1'b1;
                    mosi_d     = 1'b0;
                    send_msg_d = rx_shift_q;
                    send_val_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.send_rdy) begin
                    send_val_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = GAP;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = GAP;
            end
        endcase
    end

    assign bus.recv_rdy = recv_rdy_q;
    assign bus.send_msg = send_msg_q;
    assign bus.send_val = send_val_q;
    assign bus.cs       = cs_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
endmodule

// File: tb/tb_spi_controller.sv
module tb_spi_controller;
    localparam int BW   = 20;
    localparam int CD   = 4;
    localparam int BWB  = 8;
    localparam int CDB  = 3;
    localparam int LAT  = 2 * CD * BW + CD;
    localparam int LATB = 2 * CDB * BWB + CDB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_controller_if #(.BIT_WIDTH(BW))  ifa ();
    spi_controller_if #(.BIT_WIDTH(BWB)) ifb ();

    spi_controller #(.BIT_WIDTH(BW), .CLK_DIV(CD)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    spi_controller #(.BIT_WIDTH(BWB), .CLK_DIV(CDB)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- minion model for DUT A ----------------
    logic          loop_a = 1'b1;
    logic [BW-1:0] reply_a = '0;
    logic [BW-1:0] mosi_seen_a = '0;
    int            rise_a = 0;
    logic          minion_bit_a = 1'b0;

    assign ifa.miso = loop_a ? ifa.mosi : minion_bit_a;
    assign ifb.miso = ifb.mosi;

    // cs falling starts a new frame; each sclk rise captures mosi and launches
    // the next reply bit (worst-case launch point for the master's sampling).
    always @(negedge ifa.cs or posedge ifa.sclk) begin
        if (ifa.sclk) begin
            mosi_seen_a  = {mosi_seen_a[BW-2:0], ifa.mosi};
            minion_bit_a = (rise_a < BW) ? reply_a[BW-1-rise_a] : 1'b0;
            rise_a       = rise_a + 1;
        end else begin
            rise_a       = 0;
            mosi_seen_a  = '0;
            minion_bit_a = 1'b0;
        end
    end

    // sclk high-period statistics, cumulative
    int   hl = 0;
    int   hp_total = 0;
    int   hp_bad = 0;
    logic sclk_prev = 1'b0;
    always @(negedge clk) begin
        if (ifa.sclk) begin
            hl = hl + 1;
        end else begin
            if (sclk_prev) begin
                hp_total = hp_total + 1;
                if (hl != CD) hp_bad = hp_bad + 1;
            end
            hl = 0;
        end
        sclk_prev = ifa.sclk;
    end

    int sv_rises = 0;
    always @(posedge ifa.send_val) sv_rises = sv_rises + 1;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a minion either echoes (loopback) or returns its own word.
    function automatic logic [BW-1:0] ref_response(input logic [BW-1:0] tx,
                                                   input logic [BW-1:0] reply,
                                                   input logic loop);
        return loop ? tx : reply;
    endfunction

    task automatic xfer(input logic [BW-1:0] tx, input logic [BW-1:0] reply,
                        input logic loop, input int bp, input logic [BW-1:0] exp,
                        input string tag);
        int t;
        int acc;
        int hs;
        int hp0;
        int hb0;
        logic stable;
        logic [BW-1:0] held;
        logic [31:0] r;
        loop_a  = loop;
        reply_a = reply;
        t = 0;
        while (!ifa.recv_rdy && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " rdy_wait"}, 32'(t < 500), 32'd1);
        ifa.recv_msg = tx;
        ifa.recv_val = 1'b1;
        ifa.send_rdy = (bp == 0);
        hp0 = hp_total;
        hb0 = hp_bad;
        @(negedge clk);
        acc = cyc;
        ifa.recv_val = 1'b0;
        r = $urandom;
        ifa.recv_msg = r[BW-1:0];
        chk({tag, " cs_low"}, 32'(ifa.cs), 32'd0);
        chk({tag, " rdy_drop"}, 32'(ifa.recv_rdy), 32'd0);
        t = 0;
        while (!ifa.send_val && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " latency"}, 32'(cyc - acc), 32'(LAT));
        chk({tag, " send_msg"}, 32'(ifa.send_msg), 32'(exp));
        chk({tag, " mosi_bits"}, 32'(mosi_seen_a), 32'(tx));
        chk({tag, " sclk_rises"}, 32'(rise_a), 32'(BW));
        chk({tag, " high_periods"}, 32'(hp_total - hp0), 32'(BW));
        chk({tag, " bad_high_len"}, 32'(hp_bad - hb0), 32'd0);
        chk({tag, " cs_done"}, 32'(ifa.cs), 32'd1);
        held = ifa.send_msg;
        stable = 1'b1;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (!ifa.send_val || ifa.send_msg !== held || !ifa.cs || ifa.recv_rdy || ifa.sclk)
                stable = 1'b0;
        end
        chk({tag, " bp_stable"}, 32'(stable), 32'd1);
        ifa.send_rdy = 1'b1;
        @(negedge clk);
        hs = cyc;
        ifa.send_rdy = 1'b0;
        chk({tag, " val_drop"}, 32'(ifa.send_val), 32'd0);
        t = 0;
        while (!ifa.recv_rdy && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " gap"}, 32'(cyc - hs), 32'(CD));
        $display("xfer %s: tx=%05h reply=%05h loop=%0d bp=%0d got=%05h exp=%05h lat=%0d",
                 tag, tx, reply, loop, bp, held, exp, hs - 1 - acc - bp);
    endtask

    typedef struct {
        logic [BW-1:0] tx;
        logic [BW-1:0] reply;
        logic          loop;
        int            bp;
        logic [BW-1:0] exp;
        string         name;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic ok;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [BW-1:0] tx;
        logic [BW-1:0] rp;
        logic lp;
        int t;
        int acc;
        int sv0;
        logic [31:0] rb;

        vecs[0] = '{tx: 20'hA5C3F, reply: 20'h00000, loop: 1'b1, bp: 0,  exp: 20'hA5C3F, name: "loopback"};
        vecs[1] = '{tx: 20'h12345, reply: 20'h0F0F1, loop: 1'b0, bp: 0,  exp: 20'h0F0F1, name: "minion"};
        vecs[2] = '{tx: 20'hFFFFF, reply: 20'h80001, loop: 1'b0, bp: 50, exp: 20'h80001, name: "backpressure"};
        vecs[3] = '{tx: 20'h00000, reply: 20'hFFFFF, loop: 1'b0, bp: 3,  exp: 20'hFFFFF, name: "zeros_out"};

        ifa.recv_msg = '0;
        ifa.recv_val = 1'b0;
        ifa.send_rdy = 1'b0;
        ifb.recv_msg = '0;
        ifb.recv_val = 1'b0;
        ifb.send_rdy = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        chk("reset_cs", 32'(ifa.cs), 32'd1);
        chk("reset_send_val", 32'(ifa.send_val), 32'd0);
        chk("reset_send_msg", 32'(ifa.send_msg), 32'd0);
        reset = 1'b1;
        ok = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("rdy_after_reset_%0d", k), 32'(ifa.recv_rdy), 32'(k >= CD));
            if (!ifa.cs || ifa.sclk || ifa.mosi) ok = 1'b0;
        end
        chk("idle_pins", 32'(ok), 32'd1);
        $display("reset release: recv_rdy rose after %0d cycles", CD);

        // Table-driven vectors
        for (int i = 0; i < 4; i++)
            xfer(vecs[i].tx, vecs[i].reply, vecs[i].loop, vecs[i].bp, vecs[i].exp, vecs[i].name);

        // Randomized packets against the reference model
        for (int i = 0; i < 8; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            tx = r1[BW-1:0];
            rp = r2[BW-1:0];
            lp = r1[31];
            xfer(tx, rp, lp, int'($urandom_range(0, 12)), ref_response(tx, rp, lp),
                 $sformatf("rand%0d", i));
        end

        // Reset asserted during bit 7
        loop_a = 1'b1;
        t = 0;
        while (!ifa.recv_rdy && t < 500) begin
            @(negedge clk);
            t++;
        end
        ifa.recv_msg = 20'hC3A5E;
        ifa.recv_val = 1'b1;
        ifa.send_rdy = 1'b1;
        @(negedge clk);
        ifa.recv_val = 1'b0;
        t = 0;
        while (rise_a < 8 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reach_bit7", 32'(rise_a), 32'd8);
        sv0 = sv_rises;
        reset = 1'b0;
        #1;
        chk("abort_cs", 32'(ifa.cs), 32'd1);
        chk("abort_sclk", 32'(ifa.sclk), 32'd0);
        chk("abort_recv_rdy", 32'(ifa.recv_rdy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ifa.send_rdy = 1'b0;
        repeat (300) @(negedge clk);
        chk("abort_no_send_val", 32'(sv_rises - sv0), 32'd0);
        $display("abort: reset during bit 7, send_val rises afterwards=%0d", sv_rises - sv0);
        xfer(20'h00001, 20'h00000, 1'b1, 0, 20'h00001, "after_abort");

        // Minimum divider instance, loopback
        t = 0;
        while (!ifb.recv_rdy && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("b_rdy_wait", 32'(t < 500), 32'd1);
        ifb.recv_msg = 8'h81;
        ifb.recv_val = 1'b1;
        ifb.send_rdy = 1'b1;
        @(negedge clk);
        acc = cyc;
        ifb.recv_val = 1'b0;
        ifb.recv_msg = 8'h00;
        t = 0;
        while (!ifb.send_val && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("b_latency", 32'(cyc - acc), 32'(LATB));
        chk("b_send_msg", 32'(ifb.send_msg), 32'h81);
        $display("xfer div3: tx=81 got=%02h lat=%0d", ifb.send_msg, cyc - acc);
        @(negedge clk);
        rb = $urandom;
        t = 0;
        while (!ifb.recv_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        ifb.recv_msg = rb[BWB-1:0];
        ifb.recv_val = 1'b1;
        @(negedge clk);
        acc = cyc;
        ifb.recv_val = 1'b0;
        t = 0;
        while (!ifb.send_val && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("b_rand_latency", 32'(cyc - acc), 32'(LATB));
        chk("b_rand_msg", 32'(ifb.send_msg), 32'(rb[BWB-1:0]));
        $display("xfer div3 rand: tx=%02h got=%02h", rb[BWB-1:0], ifb.send_msg);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
